// File: rtl/draw_pkg.sv
// Shared definitions for the draw sequencer: request encodings, FSM states,
// default raster geometry and counter widths.
package draw_pkg;

   localparam int unsigned DEF_SCREEN_W = 160;
   localparam int unsigned DEF_SCREEN_H = 120;
   localparam int unsigned DEF_SPRITE_W = 40;
   localparam int unsigned DEF_SPRITE_H = 40;
   localparam int unsigned DEF_ROM_LAT  = 1;

   localparam int unsigned PIX_W = 15;   // pixel (address strobe) counter
   localparam int unsigned COL_W = 8;
   localparam int unsigned ROW_W = 7;

   typedef enum logic [1:0] {
      DT_SCREEN = 2'b00,
      DT_SPRITE = 2'b01,
      DT_CLEAR  = 2'b10,
      DT_RSVD   = 2'b11
   } draw_type_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_DRAW  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } draw_state_e;

endpackage

// File: rtl/raster_counter.sv
// Column/row tracker for the pixel currently leaving the ROM pipeline.
// Ports: clk, reset (sync, active-high), clear_i (restart at 0,0), adv_i
// (step one pixel), width_i/height_i (raster size), last_col_o, last_row_o,
// last_pixel_o (registered flags describing the current position).
module raster_counter
   import draw_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             adv_i,
   input  logic [COL_W-1:0] width_i,
   input  logic [ROW_W-1:0] height_i,
   output logic             last_col_o,
   output logic             last_row_o,
   output logic             last_pixel_o
);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             last_col_q, last_row_q, last_pixel_q;

   // Next position; row wraps to 0 after the final row.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clear_i) begin
         col_d = '0;
         row_d = '0;
      end else if (adv_i) begin
         if (col_q == width_i - COL_W'(1)) begin
            col_d = '0;
            row_d = (row_q == height_i - ROW_W'(1)) ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   // Flags are computed from the next position so they are registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         last_col_q   <= 1'b0;
         last_row_q   <= 1'b0;
         last_pixel_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         last_col_q   <= (col_d == width_i - COL_W'(1));
         last_row_q   <= (row_d == height_i - ROW_W'(1));
         last_pixel_q <= (col_d == width_i - COL_W'(1)) &&
                         (row_d == height_i - ROW_W'(1));
      end
   end

   assign last_col_o   = last_col_q;
   assign last_row_o   = last_row_q;
   assign last_pixel_o = last_pixel_q;

endmodule

// File: rtl/draw_sequencer.sv
// Control FSM for the VGA game datapath: accepts one draw request at a time
// (screen, 40x40 sprite, black clear) and sequences init loads, ROM address
// strobes, x/y counter strobes and VGA plot.
// Ports: clk, reset (sync, active-high); request side drawReq/drawType/
// reqMemSel/reqXSel/reqYSel, drawAck/busy/drawDone; datapath side latched
// selects, init loads, counter resets/strobes, black and plot. All outputs
// are registered.
// Build option: DRAW_CLEAR_EN enables the black clear draw (type 10);
// otherwise type 10 behaves like the reserved type and black is tied low.
module draw_sequencer
   import draw_pkg::*;
#(
   parameter int unsigned SCREEN_W = DEF_SCREEN_W,
   parameter int unsigned SCREEN_H = DEF_SCREEN_H,
   parameter int unsigned SPRITE_W = DEF_SPRITE_W,
   parameter int unsigned SPRITE_H = DEF_SPRITE_H,
   parameter int unsigned ROM_LAT  = DEF_ROM_LAT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       drawReq,
   input  logic [1:0] drawType,
   input  logic [4:0] reqMemSel,
   input  logic [4:0] reqXSel,
   input  logic [1:0] reqYSel,
   output logic       drawAck,
   output logic       busy,
   output logic       drawDone,
   output logic [4:0] memorySel,
   output logic [4:0] xInitSel,
   output logic [1:0] yInitSel,
   output logic       xInitLoad,
   output logic       yInitLoad,
   output logic       xReset,
   output logic       yReset,
   output logic       xCountUp,
   output logic       yCountUp,
   output logic       xLoad,
   output logic       addressScreenCounterReset,
   output logic       addressSpriteCounterReset,
   output logic       screenCountLoad,
   output logic       spriteCountLoad,
   output logic       black,
   output logic       plot
);

   localparam logic [PIX_W-1:0] SCREEN_LAST = PIX_W'(SCREEN_W * SCREEN_H - 1);
   localparam logic [PIX_W-1:0] SPRITE_LAST = PIX_W'(SPRITE_W * SPRITE_H - 1);

   // Map the raw request type onto what this build can draw.
   function automatic draw_type_e resolve_type(input logic [1:0] raw);
`ifdef DRAW_CLEAR_EN
      resolve_type = draw_type_e'(raw);
`else
      resolve_type = (draw_type_e'(raw) == DT_CLEAR) ? DT_RSVD : draw_type_e'(raw);
`endif
   endfunction

   draw_state_e      state_q, state_d;
   logic [PIX_W-1:0] cnt_q, cnt_d;
   draw_type_e       type_q, req_type;
   logic             take;
   logic             is_sprite;
   logic [PIX_W-1:0] last_idx;

   logic [ROM_LAT-1:0] pipe_q;     // address strobes travelling with ROM data
   logic               plot_d;     // pixel leaving the pipeline next cycle
   logic               last_plot_q, last_plot_d;
   logic               last_col, last_row, last_pixel;

   logic [4:0] mem_q, xsel_q;
   logic [1:0] ysel_q;
   logic ack_q, busy_q, done_q, ld_q, xup_q, yup_q, xload_q;
   logic scr_rst_q, spr_rst_q, scr_stb_q, spr_stb_q, black_q, plot_q;
   logic ack_d, busy_d, done_d, ld_d, xup_d, yup_d, xload_d;
   logic scr_rst_d, spr_rst_d, scr_stb_d, spr_stb_d, black_d, strobe_d;

   assign is_sprite = (type_q == DT_SPRITE);
   assign last_idx  = is_sprite ? SPRITE_LAST : SCREEN_LAST;
   assign plot_d    = pipe_q[ROM_LAT-1];

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_type  = resolve_type(drawType);
      take      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (drawReq) begin
               take    = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = (type_q == DT_RSVD) ? ST_DONE : ST_DRAW;
         end
         ST_DRAW: begin
            cnt_d = cnt_q + PIX_W'(1);
            if (cnt_q == last_idx) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (last_plot_q) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // LOAD is only entered from IDLE, so the raw request type is current.
      ack_d     = (state_d == ST_LOAD);
      ld_d      = ack_d;
      scr_rst_d = ack_d && (req_type == DT_SCREEN || req_type == DT_CLEAR);
      spr_rst_d = ack_d && (req_type == DT_SPRITE);
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      strobe_d  = (state_d == ST_DRAW);
      scr_stb_d = strobe_d && !is_sprite;
      spr_stb_d = strobe_d && is_sprite;
      // End of row reloads x; the final row's end has no row to step to.
      xup_d       = plot_d && !last_col;
      xload_d     = plot_d && last_col;
      yup_d       = plot_d && last_col && !last_row;
      last_plot_d = plot_d && last_pixel;
`ifdef DRAW_CLEAR_EN
      black_d   = (state_d == ST_DRAW || state_d == ST_FLUSH) && (type_q == DT_CLEAR);
`else
      black_d   = 1'b0;
`endif
   end

   // State, request capture and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         type_q      <= DT_SCREEN;
         mem_q       <= '0;
         xsel_q      <= '0;
         ysel_q      <= '0;
         pipe_q      <= '0;
         last_plot_q <= 1'b0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ld_q        <= 1'b0;
         xup_q       <= 1'b0;
         yup_q       <= 1'b0;
         xload_q     <= 1'b0;
         scr_rst_q   <= 1'b0;
         spr_rst_q   <= 1'b0;
         scr_stb_q   <= 1'b0;
         spr_stb_q   <= 1'b0;
         black_q     <= 1'b0;
         plot_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (take) begin
            type_q <= req_type;
            mem_q  <= reqMemSel;
            xsel_q <= reqXSel;
            ysel_q <= reqYSel;
         end
         pipe_q[0] <= strobe_d;
         for (int unsigned k = 1; k < ROM_LAT; k++) pipe_q[k] <= pipe_q[k-1];
         last_plot_q <= last_plot_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ld_q        <= ld_d;
         xup_q       <= xup_d;
         yup_q       <= yup_d;
         xload_q     <= xload_d;
         scr_rst_q   <= scr_rst_d;
         spr_rst_q   <= spr_rst_d;
         scr_stb_q   <= scr_stb_d;
         spr_stb_q   <= spr_stb_d;
         black_q     <= black_d;
         plot_q      <= plot_d;
      end
   end

   // Raster position of the pixel emerging from the ROM pipeline.
   raster_counter u_raster (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (state_q == ST_LOAD),
      .adv_i        (plot_d),
      .width_i      (is_sprite ? COL_W'(SPRITE_W) : COL_W'(SCREEN_W)),
      .height_i     (is_sprite ? ROW_W'(SPRITE_H) : ROW_W'(SCREEN_H)),
      .last_col_o   (last_col),
      .last_row_o   (last_row),
      .last_pixel_o (last_pixel)
   );

   assign drawAck                   = ack_q;
   assign busy                      = busy_q;
   assign drawDone                  = done_q;
   assign memorySel                 = mem_q;
   assign xInitSel                  = xsel_q;
   assign yInitSel                  = ysel_q;
   assign xInitLoad                 = ld_q;
   assign yInitLoad                 = ld_q;
   assign xReset                    = ld_q;
   assign yReset                    = ld_q;
   assign xCountUp                  = xup_q;
   assign yCountUp                  = yup_q;
   assign xLoad                     = xload_q;
   assign addressScreenCounterReset = scr_rst_q;
   assign addressSpriteCounterReset = spr_rst_q;
   assign screenCountLoad           = scr_stb_q;
   assign spriteCountLoad           = spr_stb_q;
   assign black                     = black_q;
   assign plot                      = plot_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: one instance with ROM_LAT=1 and one with
// ROM_LAT=3 share the same request inputs. Offsets t are cycles after the
// cycle in which drawReq was first presented.
module tb_draw_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       drawReq;
   logic [1:0] drawType;
   logic [4:0] reqMemSel, reqXSel;
   logic [1:0] reqYSel;

   logic drawAck, busy, drawDone, xInitLoad, yInitLoad, xReset, yReset;
   logic xCountUp, yCountUp, xLoad, scrRst, sprRst, scrLd, sprLd, black, plot;
   logic [4:0] memorySel, xInitSel;
   logic [1:0] yInitSel;

   logic a3, b3, d3, xil3, yil3, xr3, yr3, xcu3, ycu3, xl3, sr3, pr3, sl3, pl3, bl3, p3;
   logic [4:0] ms3, xs3;
   logic [1:0] ys3;

   int checks = 0;
   int errors = 0;

   int n_ack, ack1, ack2, n_plot, first_plot, last_plot, n_done, done_at, busy_at_done;
   int n_xl, n_yc, n_xc, n_scl, n_spl, n_blk;
   int ack_mem, ack_xsel, ack_ysel, ack_ld, ack_scr, ack_spr;
   int n_plot3, first_plot3, first_spl3, done3_at;

   always #5 clk = ~clk;

   draw_sequencer #(.ROM_LAT(1)) dut (
      .clk(clk), .reset(reset), .drawReq(drawReq), .drawType(drawType),
      .reqMemSel(reqMemSel), .reqXSel(reqXSel), .reqYSel(reqYSel),
      .drawAck(drawAck), .busy(busy), .drawDone(drawDone),
      .memorySel(memorySel), .xInitSel(xInitSel), .yInitSel(yInitSel),
      .xInitLoad(xInitLoad), .yInitLoad(yInitLoad), .xReset(xReset), .yReset(yReset),
      .xCountUp(xCountUp), .yCountUp(yCountUp), .xLoad(xLoad),
      .addressScreenCounterReset(scrRst), .addressSpriteCounterReset(sprRst),
      .screenCountLoad(scrLd), .spriteCountLoad(sprLd), .black(black), .plot(plot)
   );

   draw_sequencer #(.ROM_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .drawReq(drawReq), .drawType(drawType),
      .reqMemSel(reqMemSel), .reqXSel(reqXSel), .reqYSel(reqYSel),
      .drawAck(a3), .busy(b3), .drawDone(d3),
      .memorySel(ms3), .xInitSel(xs3), .yInitSel(ys3),
      .xInitLoad(xil3), .yInitLoad(yil3), .xReset(xr3), .yReset(yr3),
      .xCountUp(xcu3), .yCountUp(ycu3), .xLoad(xl3),
      .addressScreenCounterReset(sr3), .addressSpriteCounterReset(pr3),
      .screenCountLoad(sl3), .spriteCountLoad(pl3), .black(bl3), .plot(p3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Run one request, gathering statistics until both instances signal done.
   task automatic run_draw(input int lim, input bit hold);
      int t;
      n_ack = 0; ack1 = -1; ack2 = -1; n_plot = 0; first_plot = -1; last_plot = -1;
      n_done = 0; done_at = -1; busy_at_done = -1;
      n_xl = 0; n_yc = 0; n_xc = 0; n_scl = 0; n_spl = 0; n_blk = 0;
      n_plot3 = 0; first_plot3 = -1; first_spl3 = -1; done3_at = -1;
      t = 0;
      while (t < lim && !(done_at >= 0 && done3_at >= 0)) begin
         tick();
         t++;
         if (t == 1) begin
            ack_mem = int'(memorySel); ack_xsel = int'(xInitSel); ack_ysel = int'(yInitSel);
            ack_ld  = int'({xInitLoad, yInitLoad, xReset, yReset});
            ack_scr = int'(scrRst); ack_spr = int'(sprRst);
         end
         if (drawAck) begin
            n_ack++;
            if (ack1 < 0) ack1 = t; else if (ack2 < 0) ack2 = t;
            if (!hold) drawReq = 1'b0;
         end
         if (plot) begin
            n_plot++;
            if (first_plot < 0) first_plot = t;
            last_plot = t;
            if (black) n_blk++;
         end
         if (xLoad)    n_xl++;
         if (yCountUp) n_yc++;
         if (xCountUp) n_xc++;
         if (scrLd)    n_scl++;
         if (sprLd)    n_spl++;
         if (drawDone) begin
            n_done++;
            if (done_at < 0) begin done_at = t; busy_at_done = int'(busy); end
         end
         if (p3) begin n_plot3++; if (first_plot3 < 0) first_plot3 = t; end
         if (pl3 && first_spl3 < 0) first_spl3 = t;
         if (d3 && done3_at < 0) done3_at = t;
      end
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while ((busy || b3) && k < lim) begin tick(); k++; end
      chk("idle_wait", int'(busy | b3), 0);
      repeat (3) tick();
   endtask

   initial begin
      int pc, k, extra;
      reset = 1'b1; drawReq = 1'b0; drawType = 2'b00;
      reqMemSel = '0; reqXSel = '0; reqYSel = '0;
      tick(); tick();
      chk("rst_plot", int'(plot), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ack", int'(drawAck), 0);
      reset = 1'b0;
      tick();
      chk("idle_busy", int'(busy), 0);
      chk("idle_memsel", int'(memorySel), 0);

      // Full screen from ROM image 3.
      drawType = 2'b00; reqMemSel = 5'd3; drawReq = 1'b1;
      run_draw(20000, 1'b0);
      chk("scr_ack_t", ack1, 1);
      chk("scr_acks", n_ack, 1);
      chk("scr_memsel", ack_mem, 3);
      chk("scr_addr_rst", ack_scr, 1);
      chk("scr_spr_rst", ack_spr, 0);
      chk("scr_first_plot", first_plot, 3);
      chk("scr_plots", n_plot, 19200);
      chk("scr_contig", last_plot - first_plot + 1, 19200);
      chk("scr_strobes", n_scl, 19200);
      chk("scr_spr_strobes", n_spl, 0);
      chk("scr_xload", n_xl, 120);
      chk("scr_ycount", n_yc, 119);
      chk("scr_xcount", n_xc, 19080);
      chk("scr_done_t", done_at, 19203);
      chk("scr_dones", n_done, 1);
      chk("scr_busy_done", busy_at_done, 1);
      chk("scr_black", n_blk, 0);
      chk("scr_busy_after", int'(busy), 0);
      wait_idle(100);

      // Sprite at x select 4, y select 1; ROM_LAT=3 instance checked alongside.
      drawType = 2'b01; reqXSel = 5'd4; reqYSel = 2'd1; drawReq = 1'b1;
      run_draw(3000, 1'b0);
      chk("spr_xsel", ack_xsel, 4);
      chk("spr_ysel", ack_ysel, 1);
      chk("spr_loads", ack_ld, 15);
      chk("spr_addr_rst", ack_spr, 1);
      chk("spr_first_plot", first_plot, 3);
      chk("spr_plots", n_plot, 1600);
      chk("spr_contig", last_plot - first_plot + 1, 1600);
      chk("spr_strobes", n_spl, 1600);
      chk("spr_xload", n_xl, 40);
      chk("spr_ycount", n_yc, 39);
      chk("spr_xcount", n_xc, 1560);
      chk("spr_done_t", done_at, 1603);
      chk("lat3_first_strobe", first_spl3, 2);
      chk("lat3_first_plot", first_plot3, 5);
      chk("lat3_plots", n_plot3, 1600);
      chk("lat3_done_t", done3_at, 1605);
      wait_idle(100);

      // Request held through the whole draw: one ack, next two cycles after done.
      drawType = 2'b01; drawReq = 1'b1;
      run_draw(3000, 1'b1);
      chk("hold_first_ack", ack1, 1);
      chk("hold_done_t", done_at, 1603);
      chk("hold_acks", n_ack, 2);
      chk("hold_second_ack", ack2, 1605);
      drawReq = 1'b0;
      wait_idle(3000);

      // Reset at the 700th sprite plot.
      drawType = 2'b01; drawReq = 1'b1;
      tick();
      drawReq = 1'b0;
      pc = 0; k = 0;
      while (pc < 700 && k < 2000) begin
         tick(); k++;
         if (plot) pc++;
      end
      chk("rst_mid_reach", pc, 700);
      reset = 1'b1;
      tick();
      chk("rst_mid_plot", int'(plot), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_plot3", int'(p3), 0);
      reset = 1'b0;
      extra = 0;
      repeat (30) begin
         tick();
         if (drawDone || plot || busy || d3 || p3) extra++;
      end
      chk("rst_mid_quiet", extra, 0);

      // Black clear.
      drawType = 2'b10; reqMemSel = 5'd9; drawReq = 1'b1;
      run_draw(20000, 1'b0);
      chk("clr_ack_t", ack1, 1);
      chk("clr_dones", n_done, 1);
`ifdef DRAW_CLEAR_EN
      chk("clr_plots", n_plot, 19200);
      chk("clr_black", n_blk, 19200);
      chk("clr_first_plot", first_plot, 3);
      chk("clr_done_t", done_at, 19203);
`else
      chk("clr_plots", n_plot, 0);
      chk("clr_strobes", n_scl, 0);
      chk("clr_done_t", done_at, 2);
`endif
      wait_idle(100);

      // Reserved type: acked, no pixels, done right after LOAD.
      drawType = 2'b11; drawReq = 1'b1;
      run_draw(100, 1'b0);
      chk("rsv_ack_t", ack1, 1);
      chk("rsv_plots", n_plot, 0);
      chk("rsv_strobes", n_scl + n_spl, 0);
      chk("rsv_done_t", done_at, 2);
      chk("rsv_busy_done", busy_at_done, 1);
      chk("rsv_lat3_done_t", done3_at, 2);
      tick();
      chk("rsv_busy_after", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
